// File: rtl/lfsr_pkg.sv
// Shared constants for the Fibonacci LFSR random source.
// The defaults give a maximal-length 16-bit sequence (x^16+x^14+x^13+x^11+1).
package lfsr_pkg;

  localparam int unsigned LFSR16_WIDTH = 16;
  localparam logic [15:0] LFSR16_TAPS  = 16'h002D;
  localparam logic [15:0] LFSR16_SEED  = 16'hACE1;

endpackage

// File: rtl/fib_lfsr_if.sv
// Step-enable / random-bit bundle between the LFSR and its consumer.
// The consumer drives rand_en; the LFSR returns the bit and its raw state.
interface fib_lfsr_if #(
  parameter int WIDTH = 16
);

  logic             rand_en;
  logic             rand_out;
  logic [WIDTH-1:0] lfsr_state;

  modport master (
    output rand_en,
    input  rand_out,
    input  lfsr_state
  );

  modport slave (
    input  rand_en,
    output rand_out,
    output lfsr_state
  );

endinterface

// File: rtl/lfsr_feedback.sv
// Combinational feedback bit: XOR-reduce of the state bits selected by TAP_MASK.
// Zero latency; no flow control.
module lfsr_feedback
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = LFSR16_WIDTH,
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(LFSR16_TAPS)
) (
  input  logic [WIDTH-1:0] state,
  output logic             fb
);

  assign fb = ^(state & TAP_MASK);

endmodule

// File: rtl/fib_lfsr.sv
// Fibonacci LFSR: one pseudo-random bit per enabled clock, bit registered one cycle after the step.
// Holds while rand_en is low; reset and all-zero lock-up both reload the seed.
module fib_lfsr
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = LFSR16_WIDTH,
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(LFSR16_TAPS),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(LFSR16_SEED)
) (
  input  logic        clk,
  input  logic        rst,
  fib_lfsr_if.slave   lfsr_bus
);

  // An all-zero seed would park the register in its lock-up state forever.
  localparam logic [WIDTH-1:0] RESET_VAL = (SEED != '0) ? SEED : WIDTH'(1);

  logic [WIDTH-1:0] state_d, state_q;
  logic             rand_out_d, rand_out_q;
  logic             fb;

  lfsr_feedback #(
    .WIDTH    (WIDTH),
    .TAP_MASK (TAP_MASK)
  ) u_feedback (
    .state (state_q),
    .fb    (fb)
  );

  always_comb begin
    state_d    = state_q;
    rand_out_d = rand_out_q;
    if (state_q == '0) begin
      state_d    = RESET_VAL;
      rand_out_d = 1'b0;
    end else if (lfsr_bus.rand_en) begin
      state_d    = {fb, state_q[WIDTH-1:1]};
      rand_out_d = state_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RESET_VAL;
      rand_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rand_out_q <= rand_out_d;
    end
  end

  assign lfsr_bus.rand_out   = rand_out_q;
  assign lfsr_bus.lfsr_state = state_q;

endmodule

// File: tb/tb_fib_lfsr.sv
// Scoreboard bench for fib_lfsr: default 16-bit build plus a degenerate 4-bit build
// (zero seed, no taps) that walks into the all-zero state to exercise the lock-up reload.
module tb_fib_lfsr;

  logic clk;
  logic rst;

  fib_lfsr_if #(.WIDTH(16)) b16 ();
  fib_lfsr_if #(.WIDTH(4))  b4  ();

  fib_lfsr u_dut (
    .clk      (clk),
    .rst      (rst),
    .lfsr_bus (b16.slave)
  );

  fib_lfsr #(
    .WIDTH    (4),
    .TAP_MASK (4'h0),
    .SEED     (4'h0)
  ) u_zero (
    .clk      (clk),
    .rst      (rst),
    .lfsr_bus (b4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_state;
  logic        m_out;
  logic [16:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: taps at bits 0,2,3,5 written out explicitly rather than through a mask.
  task automatic model_step(input logic r, input logic en);
    logic fb;
    if (r || m_state == 16'h0000) begin
      m_state = 16'hACE1;
      m_out   = 1'b0;
    end else if (en) begin
      fb      = m_state[0] ^ m_state[2] ^ m_state[3] ^ m_state[5];
      m_out   = m_state[0];
      m_state = {fb, m_state[15:1]};
    end
  endtask

  task automatic step(input logic r, input logic en);
    logic [16:0] got;
    rst          = r;
    b16.rand_en  = en;
    model_step(r, en);
    exp_q.push_back({m_out, m_state});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      chk("state", 32'(b16.lfsr_state), 32'(got[15:0]));
      chk("rand_out", 32'(b16.rand_out), 32'(got[16]));
    end
  endtask

  initial begin
    int   first_ret;
    logic zero_seen;

    rst         = 1'b1;
    b16.rand_en = 1'b0;
    b4.rand_en  = 1'b0;
    m_state     = 16'h0000;
    m_out       = 1'b0;

    // Reset state
    step(1'b1, 1'b0);
    chk("reset_state", 32'(b16.lfsr_state), 32'hACE1);
    chk("reset_out", 32'(b16.rand_out), 32'd0);
    chk("zero_seed_reset", 32'(b4.lfsr_state), 32'h1);
    chk("zero_seed_out", 32'(b4.rand_out), 32'd0);

    // First two steps against hand-computed values
    step(1'b0, 1'b1);
    chk("step1_state", 32'(b16.lfsr_state), 32'h5670);
    chk("step1_out", 32'(b16.rand_out), 32'd1);
    step(1'b0, 1'b1);
    chk("step2_state", 32'(b16.lfsr_state), 32'hAB38);
    chk("step2_out", 32'(b16.rand_out), 32'd0);

    // Run a while, then hold for 5 cycles
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1);

    // Enable toggling pattern
    for (int i = 0; i < 20; i++) step(1'b0, logic'(i % 3 != 0));

    // Reset dominates enable
    step(1'b1, 1'b1);
    chk("rst_over_en_state", 32'(b16.lfsr_state), 32'hACE1);
    chk("rst_over_en_out", 32'(b16.rand_out), 32'd0);

    // Full period from reset: back to seed after exactly 65535 steps, never zero
    first_ret = 0;
    zero_seen = 1'b0;
    for (int i = 1; i <= 65535; i++) begin
      step(1'b0, 1'b1);
      if (b16.lfsr_state == 16'h0000) zero_seen = 1'b1;
      if (first_ret == 0 && b16.lfsr_state == 16'hACE1) first_ret = i;
    end
    chk("period_no_zero", 32'(zero_seen), 32'd0);
    chk("period_length", 32'(first_ret), 32'd65535);
    chk("period_end_state", 32'(b16.lfsr_state), 32'hACE1);

    // Lock-up guard: no taps shifts the 4-bit register down to zero, then it must reload
    rst        = 1'b0;
    b4.rand_en = 1'b1;
    @(posedge clk);
    #1;
    chk("zero_walk_state", 32'(b4.lfsr_state), 32'h0);
    chk("zero_walk_out", 32'(b4.rand_out), 32'd1);
    b4.rand_en = 1'b0;
    @(posedge clk);
    #1;
    chk("lockup_reload_state", 32'(b4.lfsr_state), 32'h1);
    chk("lockup_reload_out", 32'(b4.rand_out), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
